// File: rtl/uart_pkg.sv
// Shared definitions for the memory-mapped UART controller:
// register offsets, STATUS bit positions and the TX/RX state encodings.
package uart_pkg;

  localparam logic [31:0] UART_TXDATA = 32'h0000_1000;
  localparam logic [31:0] UART_RXDATA = 32'h0000_1004;
  localparam logic [31:0] UART_STATUS = 32'h0000_1008;

  localparam int ST_TX_FULL    = 0;
  localparam int ST_TX_IDLE    = 1;
  localparam int ST_RX_VALID   = 2;
  localparam int ST_RX_OVERRUN = 3;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_e;

  typedef enum logic [2:0] {
    RX_IDLE   = 3'd0,
    RX_START  = 3'd1,
    RX_DATA   = 3'd2,
    RX_STOP   = 3'd3,
    RX_WAITHI = 3'd4
  } rx_state_e;

endpackage

// File: rtl/uart_mmio_ctrl_if.sv
// Core data-memory port as seen by the UART controller.
interface uart_mmio_ctrl_if;
  logic [31:0] addr;
  logic        wen;
  logic        ren;
  logic [7:0]  wdata;
  logic [31:0] rdata;
  logic        stall;

  modport master (output addr, output wen, output ren, output wdata, input rdata, input stall);
  modport slave  (input addr, input wen, input ren, input wdata, output rdata, output stall);
endinterface

// File: rtl/uart_fifo.sv
// Synchronous FIFO with registered full/empty flags; DEPTH must be a power of two.
module uart_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_din,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_dout,
  output logic             o_full,
  output logic             o_empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr, r_rd_ptr;
  logic [AW:0]      r_count, w_count_n;
  logic             r_full, r_empty;
  logic             w_do_push, w_do_pop;

  assign w_do_push = i_push & ~r_full;
  assign w_do_pop  = i_pop & ~r_empty;
  assign o_dout    = r_mem[r_rd_ptr];
  assign o_full    = r_full;
  assign o_empty   = r_empty;

  always_comb begin
    w_count_n = r_count;
    if (w_do_push & ~w_do_pop) begin
      w_count_n = r_count + (AW+1)'(1);
    end else if (~w_do_push & w_do_pop) begin
      w_count_n = r_count - (AW+1)'(1);
    end else begin
      w_count_n = r_count;
    end
  end

  // Storage carries no reset; only the pointers and flags define contents.
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_din;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= w_count_n;
      r_full  <= (w_count_n == FULL_CNT);
      r_empty <= (w_count_n == '0);
    end
  end
endmodule

// File: rtl/uart_mmio_ctrl.sv
// UART controller on the core data port: TX FIFO + serial transmitter, optional polled receiver.
// The receiver is built only when UART_MMIO_RX_EN is defined.
module uart_mmio_ctrl
  import uart_pkg::*;
#(
  parameter int WAIT_DIV = 868,
  parameter int TX_DEPTH = 16
) (
  input  logic              clk,
  input  logic              rst,
  uart_mmio_ctrl_if.slave   bus,
  input  logic              uart_in,
  output logic              uart_out
);
  localparam int DIV_W = $clog2(WAIT_DIV);
  localparam logic [DIV_W-1:0] DIV_FULL = DIV_W'(WAIT_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(WAIT_DIV / 2 - 1);

  logic       w_sel_tx, w_sel_rx, w_sel_st;
  logic       w_push, w_pop, w_tx_full, w_tx_empty, w_tx_idle;
  logic [7:0] w_fifo_dout;
  logic       w_rx_valid, w_rx_overrun;
  logic [7:0] w_rx_byte;
  logic [31:0] w_rdata;
  logic [3:0]  w_status;

  assign w_sel_tx  = (bus.addr == UART_TXDATA);
  assign w_sel_rx  = (bus.addr == UART_RXDATA);
  assign w_sel_st  = (bus.addr == UART_STATUS);
  assign bus.stall = bus.wen & w_sel_tx & w_tx_full;
  assign w_push    = bus.wen & w_sel_tx & ~w_tx_full;

  uart_fifo #(.DEPTH(TX_DEPTH), .WIDTH(8)) u_tx_fifo (
    .clk(clk), .rst(rst), .i_push(w_push), .i_din(bus.wdata), .i_pop(w_pop),
    .o_dout(w_fifo_dout), .o_full(w_tx_full), .o_empty(w_tx_empty)
  );

  tx_state_e        r_tx_state, w_tx_state_n;
  logic [DIV_W-1:0] r_tx_div, w_tx_div_n;
  logic [2:0]       r_tx_bit, w_tx_bit_n;
  logic [7:0]       r_tx_shift, w_tx_shift_n;
  logic             r_uart_out, w_tx_out_n;

  // The line level is registered from the next state so uart_out never glitches.
  always_comb begin
    w_tx_state_n = r_tx_state;
    w_tx_div_n   = r_tx_div;
    w_tx_bit_n   = r_tx_bit;
    w_tx_shift_n = r_tx_shift;
    w_pop        = 1'b0;
    case (r_tx_state)
      TX_IDLE: begin
        if (!w_tx_empty) begin
          w_pop = 1'b1; w_tx_shift_n = w_fifo_dout; w_tx_div_n = DIV_FULL; w_tx_state_n = TX_START;
        end else begin
          w_tx_state_n = TX_IDLE;
        end
      end
      TX_START: begin
        if (r_tx_div == '0) begin
          w_tx_div_n = DIV_FULL; w_tx_bit_n = 3'd0; w_tx_state_n = TX_DATA;
        end else begin
          w_tx_div_n = r_tx_div - DIV_W'(1);
        end
      end
      TX_DATA: begin
        if (r_tx_div == '0) begin
          w_tx_div_n   = DIV_FULL;
          w_tx_shift_n = {1'b0, r_tx_shift[7:1]};
          if (r_tx_bit == 3'd7) begin
            w_tx_state_n = TX_STOP;
          end else begin
            w_tx_bit_n = r_tx_bit + 3'd1;
          end
        end else begin
          w_tx_div_n = r_tx_div - DIV_W'(1);
        end
      end
      TX_STOP: begin
        if (r_tx_div == '0) begin
          if (!w_tx_empty) begin
            w_pop = 1'b1; w_tx_shift_n = w_fifo_dout; w_tx_div_n = DIV_FULL; w_tx_state_n = TX_START;
          end else begin
            w_tx_state_n = TX_IDLE;
          end
        end else begin
          w_tx_div_n = r_tx_div - DIV_W'(1);
        end
      end
      default: w_tx_state_n = TX_IDLE;
    endcase
    case (w_tx_state_n)
      TX_START: w_tx_out_n = 1'b0;
      TX_DATA:  w_tx_out_n = w_tx_shift_n[0];
      default:  w_tx_out_n = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tx_state <= TX_IDLE;
      r_tx_div   <= '0;
      r_tx_bit   <= 3'd0;
      r_tx_shift <= 8'h00;
      r_uart_out <= 1'b1;
    end else begin
      r_tx_state <= w_tx_state_n;
      r_tx_div   <= w_tx_div_n;
      r_tx_bit   <= w_tx_bit_n;
      r_tx_shift <= w_tx_shift_n;
      r_uart_out <= w_tx_out_n;
    end
  end

  assign uart_out  = r_uart_out;
  assign w_tx_idle = w_tx_empty & (r_tx_state == TX_IDLE);

`ifdef UART_MMIO_RX_EN
  logic [1:0]       r_rx_sync;
  logic             w_rx_in;
  rx_state_e        r_rx_state, w_rx_state_n;
  logic [DIV_W-1:0] r_rx_div, w_rx_div_n;
  logic [2:0]       r_rx_bit, w_rx_bit_n;
  logic [7:0]       r_rx_shift, w_rx_shift_n;
  logic [7:0]       r_rx_byte;
  logic             r_rx_valid, r_rx_overrun;
  logic             w_rx_done, w_rd_clear, w_ovr_clear;

  assign w_rx_in     = r_rx_sync[1];
  assign w_rd_clear  = bus.ren & w_sel_rx & r_rx_valid;
  assign w_ovr_clear = bus.wen & w_sel_st & bus.wdata[ST_RX_OVERRUN];

  always_comb begin
    w_rx_state_n = r_rx_state;
    w_rx_div_n   = r_rx_div;
    w_rx_bit_n   = r_rx_bit;
    w_rx_shift_n = r_rx_shift;
    w_rx_done    = 1'b0;
    case (r_rx_state)
      RX_IDLE: begin
        if (!w_rx_in) begin
          w_rx_div_n = DIV_HALF; w_rx_state_n = RX_START;
        end else begin
          w_rx_state_n = RX_IDLE;
        end
      end
      RX_START: begin
        if (r_rx_div == '0) begin
          if (!w_rx_in) begin
            w_rx_div_n = DIV_FULL; w_rx_bit_n = 3'd0; w_rx_state_n = RX_DATA;
          end else begin
            w_rx_state_n = RX_IDLE;
          end
        end else begin
          w_rx_div_n = r_rx_div - DIV_W'(1);
        end
      end
      RX_DATA: begin
        if (r_rx_div == '0) begin
          w_rx_div_n   = DIV_FULL;
          w_rx_shift_n = {w_rx_in, r_rx_shift[7:1]};
          if (r_rx_bit == 3'd7) begin
            w_rx_state_n = RX_STOP;
          end else begin
            w_rx_bit_n = r_rx_bit + 3'd1;
          end
        end else begin
          w_rx_div_n = r_rx_div - DIV_W'(1);
        end
      end
      RX_STOP: begin
        if (r_rx_div == '0) begin
          if (w_rx_in) begin
            w_rx_done = 1'b1; w_rx_state_n = RX_IDLE;
          end else begin
            w_rx_state_n = RX_WAITHI;
          end
        end else begin
          w_rx_div_n = r_rx_div - DIV_W'(1);
        end
      end
      RX_WAITHI: begin
        if (w_rx_in) begin
          w_rx_state_n = RX_IDLE;
        end else begin
          w_rx_state_n = RX_WAITHI;
        end
      end
      default: w_rx_state_n = RX_IDLE;
    endcase
  end

  // A completing frame beats a same-cycle read-clear; that case is not an overrun.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rx_sync    <= 2'b11;
      r_rx_state   <= RX_IDLE;
      r_rx_div     <= '0;
      r_rx_bit     <= 3'd0;
      r_rx_shift   <= 8'h00;
      r_rx_byte    <= 8'h00;
      r_rx_valid   <= 1'b0;
      r_rx_overrun <= 1'b0;
    end else begin
      r_rx_sync  <= {r_rx_sync[0], uart_in};
      r_rx_state <= w_rx_state_n;
      r_rx_div   <= w_rx_div_n;
      r_rx_bit   <= w_rx_bit_n;
      r_rx_shift <= w_rx_shift_n;
      if (w_rx_done) begin
        r_rx_byte  <= r_rx_shift;
        r_rx_valid <= 1'b1;
      end else if (w_rd_clear) begin
        r_rx_valid <= 1'b0;
      end
      if (w_rx_done & r_rx_valid & ~w_rd_clear) begin
        r_rx_overrun <= 1'b1;
      end else if (w_ovr_clear) begin
        r_rx_overrun <= 1'b0;
      end
    end
  end

  assign w_rx_valid   = r_rx_valid;
  assign w_rx_overrun = r_rx_overrun;
  assign w_rx_byte    = r_rx_byte;
`else
  logic [1:0] w_unused_rx;
  assign w_unused_rx  = {uart_in, bus.ren};
  assign w_rx_valid   = 1'b0;
  assign w_rx_overrun = 1'b0;
  assign w_rx_byte    = 8'h00;
`endif

  always_comb begin
    w_status                = 4'h0;
    w_status[ST_TX_FULL]    = w_tx_full;
    w_status[ST_TX_IDLE]    = w_tx_idle;
    w_status[ST_RX_VALID]   = w_rx_valid;
    w_status[ST_RX_OVERRUN] = w_rx_overrun;
    case (bus.addr)
      UART_RXDATA: w_rdata = {23'h0, w_rx_valid, w_rx_byte};
      UART_STATUS: w_rdata = {28'h0, w_status};
      default:     w_rdata = 32'h0;
    endcase
  end

  assign bus.rdata = w_rdata;
endmodule
